truth_table_checker: RTL and testbench
======================================

# truth_table_checker

- Synthesizable response checker for a 3-input combinational gate under test.
- Sequences all eight input vectors {a,b,c} = 0..7 onto the gate and waits a programmable settle time per vector so gate and wire delays can resolve.
- Samples the gate output, captures the full 8-entry response and compares it against an expected truth table.
- Sits beside the gate as the on-chip counterpart to a stimulus bench: it drives the inputs and judges the output.

## Interface
- SETTLE, 10: cycles each vector is held before its sample cycle; legal range ≥1.
- EXPECTED, 8'hE8: expected truth table, bit i = expected y for {a,b,c} = i (default is 3-input majority).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- a, b, c  out  1 each  drive to gate under test; {a,b,c} = current vector index.
- y  in  1  gate output under test.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  err_count==0 for the last completed sweep.
- captured  out  8  sampled y per vector; bit i = y observed for vector i.
- err_count  out  4  number of mismatching vectors, 0..8.
- first_fail  out  3  lowest failing vector index.
- fail_valid  out  1  at least one mismatch recorded.

## Operation
- FSM states:
  - IDLE: a,b,c held at 0.
  - SETTLE: counter runs 0..SETTLE-1.
  - SAMPLE: one cycle.
  - FINISH: one cycle.
- IDLE + start=1: go to SETTLE. On that same edge: vec←0, settle counter←0, captured←0, err_count←0, first_fail←0, fail_valid←0, pass←0.
- SETTLE: counter increments each cycle. When counter==SETTLE-1, go to SAMPLE.
- SAMPLE, on the edge leaving it:
  - captured[vec]←y.
  - If y≠EXPECTED[vec]: err_count+1. If fail_valid was 0, also first_fail←vec and fail_valid←1.
  - If vec==7, go to FINISH. Otherwise vec+1, counter←0, go to SETTLE.
- FINISH: done=1 for this cycle only. On exit: pass←(err_count==0), then go to IDLE.
- Results (captured, err_count, first_fail, fail_valid, pass) hold until the next accepted start.
- start in SETTLE, SAMPLE or FINISH is ignored. No queuing.
- busy=1 in SETTLE and SAMPLE. busy=0 in IDLE and FINISH.
- Settle counter width: $clog2(SETTLE+1). err_count cannot exceed 8, so it needs no saturation.

## Timing
- Reset values: a=b=c=0, busy=0, done=0, pass=0, captured=8'h00, err_count=0, first_fail=0, fail_valid=0, state IDLE.
- Each vector is driven for SETTLE+1 cycles. y is sampled at the end of the last of those cycles.
- start accepted at edge 0:
  - busy high for cycles 1..8·(SETTLE+1).
  - done high in cycle 8·(SETTLE+1)+1.
  - pass valid from the following cycle.
  - With the default SETTLE this is 88 busy cycles and done in cycle 89.
- a,b,c change only on the edge entering SETTLE for a new vector. They are stable through that vector's SETTLE and SAMPLE cycles, and return to 0 on entry to IDLE.
- Reset asserted mid-sweep: immediate abort, all outputs take reset values, and no done pulse is produced.
- start held high continuously: a new sweep begins on the first IDLE cycle after FINISH.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> all outputs take reset values asynchronously. Release, then idle 5 cycles -> busy=0, a,b,c=0.
- Good gate: y=majority(a,b,c) combinational, default parameters, pulse start -> busy for 88 cycles, done in cycle 89, captured=8'hE8, err_count=0, fail_valid=0, pass=1.
- Stuck-at-0: y=0 -> captured=8'h00, err_count=4, first_fail=3, fail_valid=1, pass=0.
- Single fault: majority, but y inverted only when {a,b,c}=5 -> captured=8'hC8, err_count=1, first_fail=5, pass=0.
- Slow gate: majority delayed by a register chain longer than SETTLE+1 but shorter than 2·(SETTLE+1) cycles, so each sample sees the previous vector's response -> err_count=3, first_fail=3, pass=0. Same gate with SETTLE raised above the delay -> pass=1.
- Control: start pulsed at cycle 30 of a sweep -> ignored, done still in cycle 89. Then rst_n low at cycle 40 of a second sweep -> abort, no done, reset values. Then start again -> full sweep completes with correct results.

Source files
------------

// File: rtl/truth_table_checker.sv
// On-chip response checker for a 3-input combinational gate: sweeps all eight
// input vectors, waits SETTLE cycles per vector, samples y and grades it against EXPECTED.
module truth_table_checker #(
    parameter int unsigned SETTLE   = 10,
    parameter logic [7:0]  EXPECTED = 8'hE8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    input  logic       y_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [7:0] captured_o,
    output logic [3:0] err_count_o,
    output logic [2:0] first_fail_o,
    output logic       fail_valid_o
);

    localparam int unsigned CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_FINISH
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    vec_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic [7:0]    captured_q;
    logic [3:0]    err_q;
    logic [2:0]    ff_q;
    logic          fv_q;

    // Sweep sequencer; every output is a register updated on the transition that defines it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            vec_q      <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            captured_q <= 8'h00;
            err_q      <= 4'd0;
            ff_q       <= 3'd0;
            fv_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q    <= S_SETTLE;
                        vec_q      <= 3'd0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        captured_q <= 8'h00;
                        err_q      <= 4'd0;
                        ff_q       <= 3'd0;
                        fv_q       <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(SETTLE - 1)) begin
                        state_q <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    captured_q[vec_q] <= y_i;
                    if (y_i != EXPECTED[vec_q]) begin
                        err_q <= err_q + 4'd1;
                        if (!fv_q) begin
                            ff_q <= vec_q;
                            fv_q <= 1'b1;
                        end
                    end
                    if (vec_q == 3'd7) begin
                        state_q <= S_FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        vec_q   <= vec_q + 3'd1;
                        cnt_q   <= '0;
                        state_q <= S_SETTLE;
                    end
                end
                S_FINISH: begin
                    pass_q  <= (err_q == 4'd0);
                    vec_q   <= 3'd0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The vector index doubles as the gate stimulus {a,b,c}.
    assign a_o          = vec_q[2];
    assign b_o          = vec_q[1];
    assign c_o          = vec_q[0];
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign captured_o   = captured_q;
    assign err_count_o  = err_q;
    assign first_fail_o = ff_q;
    assign fail_valid_o = fv_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: model gates (good, stuck, single-fault, slow)
// swept from a record table, plus start-intrusion, mid-sweep reset and held-start sequences.
module tb_truth_table_checker;

    localparam int unsigned S1  = 10;
    localparam int unsigned S2  = 16;
    localparam int unsigned DLY = 15;

    typedef struct {
        int         sel;
        int         mode;
        logic [7:0] cap;
        logic [3:0] errs;
        logic [2:0] ff;
        logic       fv;
        logic       pass;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start1, start2;
    logic       a1, b1, c1, y1, busy1, done1, pass1, fv1;
    logic [7:0] cap1;
    logic [3:0] err1;
    logic [2:0] ff1;
    logic       a2, b2, c2, y2, busy2, done2, pass2, fv2;
    logic [7:0] cap2;
    logic [3:0] err2;
    logic [2:0] ff2;

    int n_cmp = 0;
    int n_err = 0;
    int sel   = 0;
    int mode  = 0;
    rec_t tbl[5];
    rec_t sbq[$];

    truth_table_checker #(.SETTLE(S1), .EXPECTED(8'hE8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1),
        .a_o(a1), .b_o(b1), .c_o(c1), .y_i(y1),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .captured_o(cap1), .err_count_o(err1), .first_fail_o(ff1), .fail_valid_o(fv1)
    );

    truth_table_checker #(.SETTLE(S2), .EXPECTED(8'hE8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2),
        .a_o(a2), .b_o(b2), .c_o(c2), .y_i(y2),
        .busy_o(busy2), .done_o(done2), .pass_o(pass2),
        .captured_o(cap2), .err_count_o(err2), .first_fail_o(ff2), .fail_valid_o(fv2)
    );

    function automatic logic maj(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    // Gate models: the slow gate is majority through a DLY-stage register chain.
    logic [DLY-1:0] ch1 = '0;
    logic [DLY-1:0] ch2 = '0;
    always @(posedge clk) begin
        ch1 <= {ch1[DLY-2:0], maj({a1, b1, c1})};
        ch2 <= {ch2[DLY-2:0], maj({a2, b2, c2})};
    end

    assign y1 = (mode == 1) ? 1'b0 :
                (mode == 2) ? (maj({a1, b1, c1}) ^ ({a1, b1, c1} == 3'd5)) :
                (mode == 3) ? ch1[DLY-1] : maj({a1, b1, c1});
    assign y2 = ch2[DLY-1];

    logic       busy_m, done_m, pass_m, fv_m;
    logic [2:0] abc_m, ff_m;
    logic [3:0] err_m;
    logic [7:0] cap_m;
    assign busy_m = (sel != 0) ? busy2 : busy1;
    assign done_m = (sel != 0) ? done2 : done1;
    assign pass_m = (sel != 0) ? pass2 : pass1;
    assign fv_m   = (sel != 0) ? fv2 : fv1;
    assign abc_m  = (sel != 0) ? {a2, b2, c2} : {a1, b1, c1};
    assign ff_m   = (sel != 0) ? ff2 : ff1;
    assign err_m  = (sel != 0) ? err2 : err1;
    assign cap_m  = (sel != 0) ? cap2 : cap1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel != 0) start2 = v;
        else          start1 = v;
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_abc"},   32'({a1, b1, c1}), 32'd0);
        check({tag, "_busy"},  32'(busy1), 32'd0);
        check({tag, "_done"},  32'(done1), 32'd0);
        check({tag, "_pass"},  32'(pass1), 32'd0);
        check({tag, "_cap"},   32'(cap1),  32'h00);
        check({tag, "_err"},   32'(err1),  32'd0);
        check({tag, "_ff"},    32'(ff1),   32'd0);
        check({tag, "_fv"},    32'(fv1),   32'd0);
    endtask

    // One full sweep of table entry idx; intrude_at>0 pulses start at that sweep cycle.
    task automatic run_sweep(input int idx, input int intrude_at);
        rec_t r, e;
        int   s, cyc, done_cyc, busy_n;
        logic got;
        r    = tbl[idx];
        sel  = r.sel;
        mode = r.mode;
        s    = (sel != 0) ? int'(S2) : int'(S1);
        repeat (DLY + 5) @(negedge clk);
        sbq.push_back(r);
        set_start(1'b1);
        @(negedge clk);
        cyc = 1; got = 1'b0; busy_n = 0; done_cyc = 0;
        while (!got && cyc < 400) begin
            set_start(cyc == intrude_at);
            if (busy_m) busy_n++;
            if (cyc == s + 2)           check($sformatf("t%0d_abc_v1", idx), 32'(abc_m), 32'd1);
            if (cyc == 7 * (s + 1) + 1) check($sformatf("t%0d_abc_v7", idx), 32'(abc_m), 32'd7);
            if (done_m) begin
                got      = 1'b1;
                done_cyc = cyc;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        set_start(1'b0);
        e = sbq.pop_front();
        check($sformatf("t%0d_done_seen", idx), 32'(got), 32'd1);
        if (got) begin
            check($sformatf("t%0d_done_cyc", idx), 32'(done_cyc), 32'(8 * (s + 1) + 1));
            check($sformatf("t%0d_busy_cyc", idx), 32'(busy_n), 32'(8 * (s + 1)));
            @(negedge clk);
            check($sformatf("t%0d_done_pulse", idx), 32'(done_m), 32'd0);
            check($sformatf("t%0d_cap", idx),  32'(cap_m),  32'(e.cap));
            check($sformatf("t%0d_err", idx),  32'(err_m),  32'(e.errs));
            check($sformatf("t%0d_ff", idx),   32'(ff_m),   32'(e.ff));
            check($sformatf("t%0d_fv", idx),   32'(fv_m),   32'(e.fv));
            check($sformatf("t%0d_pass", idx), 32'(pass_m), 32'(e.pass));
        end
    endtask

    initial begin
        int   seen, n;
        rst_n  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        tbl[0] = '{0, 0, 8'hE8, 4'd0, 3'd0, 1'b0, 1'b1};
        tbl[1] = '{0, 1, 8'h00, 4'd4, 3'd3, 1'b1, 1'b0};
        tbl[2] = '{0, 2, 8'hC8, 4'd1, 3'd5, 1'b1, 1'b0};
        tbl[3] = '{0, 3, 8'hD0, 4'd3, 3'd3, 1'b1, 1'b0};
        tbl[4] = '{1, 3, 8'hE8, 4'd0, 3'd0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check_rst("rst0");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(busy1), 32'd0);
        check("idle_abc",  32'({a1, b1, c1}), 32'd0);

        for (int i = 0; i < 5; i++) run_sweep(i, 0);

        // Start pulsed mid-sweep must be ignored.
        run_sweep(0, 30);

        // Asynchronous reset at cycle 40 of a sweep aborts it.
        sel = 0; mode = 0;
        repeat (DLY + 5) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (39) @(negedge clk);
        check("abort_busy_before", 32'(busy1), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_rst("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (done1) seen = 1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        check("abort_idle_busy", 32'(busy1), 32'd0);
        run_sweep(0, 0);

        // Start held high: a new sweep starts on the first IDLE cycle after FINISH.
        sel = 0; mode = 0;
        repeat (DLY + 5) @(negedge clk);
        start1 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!done1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("held_done_seen", 32'(done1), 32'd1);
        @(negedge clk);
        check("held_idle_busy", 32'(busy1), 32'd0);
        check("held_pass", 32'(pass1), 32'd1);
        @(negedge clk);
        check("held_restart_busy", 32'(busy1), 32'd1);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("held_second_done", 32'(done1), 32'd1);
        @(negedge clk);
        check("held_second_cap", 32'(cap1), 32'hE8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
